fir4_chan_sched: RTL
====================

Name: fir4_chan_sched

Overview:
Multi-channel scheduler for the 4-tap unweighted FIR sum (y = x[n] + x[n-1] + x[n-2] + x[n-3]). NCH independent sample streams share one 4-operand adder datapath through a round-robin arbiter. The block keeps a 3-sample history per channel and issues one channel's operands per cycle. Results return on a single valid/ready output tagged with their channel index.

Parameters:
w, 16, sample width (signed two's complement)
NCH, 4, number of channels (2..16)
CHW, $clog2(NCH), channel index width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
in_valid  input  NCH  per-channel sample valid
in_data  input  NCH*w  per-channel samples, channel i at bits [i*w +: w], signed
in_ready  output  NCH  per-channel grant; one-hot or zero
clr_valid  input  1  clear-history request
clr_chan  input  CHW  channel whose history is cleared
out_valid  output  1  result valid
out_data  output  w+2  signed 4-tap sum
out_chan  output  CHW  channel of out_data
out_ready  input  1  downstream accepts result
busy  output  1  stage-1 or output register holds a valid item

Behaviour:
- Reset values: out_valid=0, out_data=0, out_chan=0, busy=0, every history register 0, RR pointer=0, stage-1 valid=0. in_ready=0 while reset is high. A reset mid-operation drops all in-flight items. It produces no output for them.
- adv = !out_valid || out_ready. The pipeline moves only when adv=1.
- Arbiter:
  - in_ready is combinational from in_valid, the RR pointer and adv.
  - When adv=1, in_ready = one-hot grant to the first channel with in_valid=1, searching from the RR pointer upward and wrapping at NCH-1 to 0.
  - When adv=0 or no in_valid is high, in_ready = 0.
- Accept: occurs on a rising edge where in_valid[k] && in_ready[k]. Then:
  - RR pointer <= (k+1) mod NCH.
  - Stage-1 operands <= {x, h0[k], h1[k], h2[k]}.
  - History shifts: h2<=h1, h1<=h0, h0<=x.
  - Stage-1 valid <= 1, with tag k.
  - With no accept, the RR pointer holds.
- Stage 2: when adv=1 and stage-1 valid=1, out_data <= sign-extended sum of the 4 operands at full width w+2 (no saturation, no overflow possible). Also out_chan <= tag and out_valid <= 1.
- When adv=1 and stage-1 is empty, out_valid <= 0.
- Latency: sample accepted at edge k gives out_valid=1 from edge k+1, with a throughput of 1 result/cycle.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data and out_chan stay stable.
  - Stage 1 holds its contents.
  - in_ready=0 on all channels.
  - No sample is lost or duplicated.
- Clear:
  - When clr_valid=1, h0/h1/h2 of clr_chan are zeroed on that edge.
  - If the same channel is accepted on the same edge, the accepted sample uses zero history (operands {x,0,0,0}) and the history becomes {x,0,0}.
  - Clear affects no other channel and does not affect items already in stage 1 or the output register.
  - clr_chan >= NCH is ignored.
- busy = stage-1 valid || out_valid.

Test Plan:
- Impulse on ch0: samples 100,0,0,0,0 (other channels idle, out_ready=1) -> outputs 100,100,100,100,0, all out_chan=0, each result 1 cycle after its accept.
- Extremes on ch1: four samples of 32767 -> 4th result 131068. After clear, four samples of -32768 -> 4th result -131072 (18-bit exact).
- Round-robin fairness: all 4 in_valid held high for 8 cycles -> grants 0,1,2,3,0,1,2,3. out_chan follows the same order one cycle later, with no gaps.
- Channel independence: ch0 fed 1,2,3,4 interleaved with ch2 fed 10,20,30,40 -> ch0 results 1,3,6,10; ch2 results 10,30,60,100.
- Backpressure: out_ready low for 5 cycles with 2 items in flight -> out_valid held, out_data stable, in_ready=0. On release, both results are delivered in order and no sample is lost.
- Clear and reset: clr on ch3 coincident with accept of 7 after history 5,5,5 -> result 7. Reset asserted with an item in stage 1 -> out_valid=0 next cycle and histories zero.

Source files
------------

// File: rtl/fir4_chan_sched.sv
// ============================================================================
// Module   : fir4_chan_sched
// Brief    : Multi-channel 4-tap unweighted FIR (x[n]+x[n-1]+x[n-2]+x[n-3]).
//            NCH sample streams share one 4-operand adder through a
//            round-robin arbiter. Each channel keeps a 3-sample history.
//            Results leave on one valid/ready port tagged with the channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir4_chan_sched #(
  parameter  int w   = 16,
  parameter  int NCH = 4,
  localparam int CHW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*w-1:0] in_data,
  output logic [NCH-1:0]   in_ready,
  input  logic             clr_valid,
  input  logic [CHW-1:0]   clr_chan,
  output logic             out_valid,
  output logic [w+1:0]     out_data,
  output logic [CHW-1:0]   out_chan,
  input  logic             out_ready,
  output logic             busy
);

  // Per-channel sample history: h0 is the newest stored sample.
  logic [w-1:0]   r_h0 [NCH];
  logic [w-1:0]   r_h1 [NCH];
  logic [w-1:0]   r_h2 [NCH];

  // Round-robin search start.
  logic [CHW-1:0] r_rr;

  // Stage 1: the four operands of the granted channel plus its tag.
  logic           r_s1_valid;
  logic [w-1:0]   r_s1_x;
  logic [w-1:0]   r_s1_a;
  logic [w-1:0]   r_s1_b;
  logic [w-1:0]   r_s1_c;
  logic [CHW-1:0] r_s1_tag;

  // Output register.
  logic           r_out_valid;
  logic [w+1:0]   r_out_data;
  logic [CHW-1:0] r_out_chan;

  // Combinational helpers.
  logic           w_adv;
  logic [NCH-1:0] w_grant;
  logic           w_acc;
  logic [CHW-1:0] w_acc_idx;
  logic [w-1:0]   w_acc_x;
  logic [w-1:0]   w_eff_h0;
  logic [w-1:0]   w_eff_h1;
  logic [w-1:0]   w_eff_h2;
  logic [NCH-1:0] w_clr_hit;
  logic [w+1:0]   w_sum;

  // The whole pipeline advances together whenever the output slot can move.
  assign w_adv = !r_out_valid || out_ready;

  // Round-robin arbiter: first requesting channel at or above the pointer.
  always_comb begin
    logic found;
    int   j;
    w_grant   = '0;
    w_acc_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int i = 0; i < NCH; i++) begin
      j = int'(r_rr) + i;
      if (j >= NCH) begin
        j = j - NCH;
      end
      if (!found && in_valid[j]) begin
        found      = 1'b1;
        w_grant[j] = 1'b1;
        w_acc_idx  = CHW'(j);
      end
    end
    if (reset || !w_adv) begin
      w_grant = '0;
    end
  end

  assign w_acc    = |w_grant;
  assign in_ready = w_grant;

  // Decode the clear request; out-of-range channel numbers match nothing.
  always_comb begin
    w_clr_hit = '0;
    for (int k = 0; k < NCH; k++) begin
      w_clr_hit[k] = clr_valid && (clr_chan == CHW'(k));
    end
  end

  // Select the granted sample and its history; a same-edge clear zeroes it.
  always_comb begin
    w_acc_x  = '0;
    w_eff_h0 = '0;
    w_eff_h1 = '0;
    w_eff_h2 = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_acc_idx == CHW'(k)) begin
        w_acc_x = in_data[k*w +: w];
        if (!w_clr_hit[k]) begin
          w_eff_h0 = r_h0[k];
          w_eff_h1 = r_h1[k];
          w_eff_h2 = r_h2[k];
        end
      end
    end
  end

  // History update: shift in accepted samples, zero cleared channels.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (reset) begin
        r_h0[k] <= '0;
        r_h1[k] <= '0;
        r_h2[k] <= '0;
      end else if (w_grant[k]) begin
        r_h0[k] <= w_acc_x;
        r_h1[k] <= w_clr_hit[k] ? '0 : r_h0[k];
        r_h2[k] <= w_clr_hit[k] ? '0 : r_h1[k];
      end else if (w_clr_hit[k]) begin
        r_h0[k] <= '0;
        r_h1[k] <= '0;
        r_h2[k] <= '0;
      end
    end
  end

  // Round-robin pointer moves just past the channel that was served.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr <= '0;
    end else if (w_acc) begin
      r_rr <= (w_acc_idx == CHW'(NCH - 1)) ? '0 : w_acc_idx + CHW'(1);
    end
  end

  // Stage 1 captures operands of the accepted sample; holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_c     <= '0;
      r_s1_tag   <= '0;
    end else if (w_adv) begin
      r_s1_valid <= w_acc;
      if (w_acc) begin
        r_s1_x   <= w_acc_x;
        r_s1_a   <= w_eff_h0;
        r_s1_b   <= w_eff_h1;
        r_s1_c   <= w_eff_h2;
        r_s1_tag <= w_acc_idx;
      end
    end
  end

  // Four sign-extended operands summed at w+2 bits, which cannot overflow.
  assign w_sum = {{2{r_s1_x[w-1]}}, r_s1_x} + {{2{r_s1_a[w-1]}}, r_s1_a}
               + {{2{r_s1_b[w-1]}}, r_s1_b} + {{2{r_s1_c[w-1]}}, r_s1_c};

  // Output register: loads the stage-1 sum, empties when nothing follows.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
    end else if (w_adv) begin
      if (r_s1_valid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sum;
        r_out_chan  <= r_s1_tag;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign busy      = r_s1_valid || r_out_valid;

endmodule

`default_nettype wire
